// File: rtl/umips_pkg.sv
// Shared umips fetch definitions: widths, fetch FSM encoding and the pc/instr payload.
package umips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(0);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_SKID  = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_word_t;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] pc_step(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(4);
    endfunction

endpackage

// File: rtl/umips_fetch_ctrl_if.sv
// Fetch-stage bundle: decode control in, imem handshake, and the word presented to decode.
interface umips_fetch_ctrl_if;
    import umips_pkg::*;

    logic                stall;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                exc;
    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                if_valid;
    logic [ADDR_W-1:0]   if_pc;
    logic [INSTR_W-1:0]  if_instr;

    modport master (
        input  stall, redirect, redirect_pc, exc, imem_ack, imem_rdata,
        output imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output stall, redirect, redirect_pc, exc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr
    );

endinterface

// File: rtl/umips_fetch_skid.sv
// One-entry pc/instr holding register used when decode stalls on a returning fetch.
module umips_fetch_skid
    import umips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_flush,
    input  fetch_word_t i_word,
    output logic        o_valid,
    output fetch_word_t o_word
);

    logic        r_valid;
    fetch_word_t r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (i_flush || i_unload) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_word  <= i_word;
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;

endmodule

// File: rtl/umips_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the imem req/ack handshake and
// feeds decode through an output register backed by a one-entry skid.
module umips_fetch_ctrl
    import umips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] EXC_PC   = 32'h0000_0080
) (
    input  logic               clk,
    input  logic               rst,
    umips_fetch_ctrl_if.master io_fetch
);

    logic [1:0]        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_squash, w_squash_nxt;
    logic              r_if_valid, w_if_valid_nxt;
    fetch_word_t       r_out, w_out_nxt;

    logic              w_req_c;
    logic              w_flush, w_slot_free, w_consume;
    logic [ADDR_W-1:0] w_target, w_pc_inc;
    fetch_word_t       w_mem_word, w_skid_in, w_skid_word;
    logic              w_skid_load, w_skid_unload, w_skid_valid;

    assign w_flush     = io_fetch.exc || io_fetch.redirect;
    assign w_target    = io_fetch.exc ? EXC_PC : io_fetch.redirect_pc;
    assign w_slot_free = !r_if_valid || !io_fetch.stall;
    assign w_consume   = r_if_valid && !io_fetch.stall && !w_flush;
    assign w_pc_inc    = pc_step(r_pc);

    assign w_mem_word.pc    = r_pc;
    assign w_mem_word.instr = io_fetch.imem_rdata;
    assign w_skid_in.pc     = r_addr;
    assign w_skid_in.instr  = io_fetch.imem_rdata;

    umips_fetch_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_flush  (w_flush),
        .i_word   (w_skid_in),
        .o_valid  (w_skid_valid),
        .o_word   (w_skid_word)
    );

    // Next-state, next-datapath and request logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_squash_nxt   = r_squash;
        w_if_valid_nxt = r_if_valid && !w_consume;
        w_out_nxt      = r_out;
        w_req_c        = 1'b0;
        w_skid_load    = 1'b0;
        w_skid_unload  = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_req_c = w_slot_free && !w_flush;
                if (w_req_c && io_fetch.imem_ack) begin
                    w_if_valid_nxt = 1'b1;
                    w_out_nxt      = w_mem_word;
                    w_pc_nxt       = w_pc_inc;
                end else if (w_req_c) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A raised request is held until the memory answers.
                w_req_c = 1'b1;
                if (io_fetch.imem_ack) begin
                    if (r_squash) begin
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = ST_FETCH;
                    end else if (w_slot_free) begin
                        w_if_valid_nxt = 1'b1;
                        w_out_nxt      = w_mem_word;
                        w_pc_nxt       = w_pc_inc;
                        w_state_nxt    = ST_FETCH;
                    end else begin
                        w_skid_load = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = ST_SKID;
                    end
                end
            end
            ST_SKID: begin
                if (!io_fetch.stall) begin
                    w_if_valid_nxt = w_skid_valid;
                    w_out_nxt      = w_skid_word;
                    w_skid_unload  = 1'b1;
                    w_state_nxt    = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase

        // Redirect/exception wins; an unanswered request is left to drain as squashed.
        if (w_flush) begin
            w_pc_nxt       = w_target;
            w_if_valid_nxt = 1'b0;
            w_skid_load    = 1'b0;
            if (r_state == ST_WAIT && !io_fetch.imem_ack) begin
                w_squash_nxt = 1'b1;
                w_state_nxt  = ST_WAIT;
            end else begin
                w_squash_nxt = 1'b0;
                w_state_nxt  = ST_FETCH;
            end
        end

        w_addr_nxt = (w_state_nxt == ST_WAIT) ? r_addr : w_pc_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_squash    <= 1'b0;
            r_if_valid  <= 1'b0;
            r_out.pc    <= ADDR_W'(0);
            r_out.instr <= NOP;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_squash   <= w_squash_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_out      <= w_out_nxt;
        end
    end

    assign io_fetch.imem_req  = w_req_c;
    assign io_fetch.imem_addr = r_addr;
    assign io_fetch.if_valid  = r_if_valid;
    assign io_fetch.if_pc     = r_out.pc;
    assign io_fetch.if_instr  = r_out.instr;

endmodule
